// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified I/D memory port arbiter.
package mem_arb_pkg;
  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_MEM_LATENCY     = 2;
  localparam int DEF_MAX_DATA_STREAK = 4;

  typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU fetch/data ports and the single memory port. master = CPU + memory side, slave = arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AddrWidth = DEF_ADDR_W,
  parameter int DataWidth = DEF_DATA_W
);
  logic                 IReq;
  logic [AddrWidth-1:0] IAddr;
  logic                 IGnt;
  logic                 IValid;
  logic [DataWidth-1:0] IRData;
  logic                 DReq;
  logic                 DWrite;
  logic [AddrWidth-1:0] DAddr;
  logic [DataWidth-1:0] DWData;
  logic                 DGnt;
  logic                 DValid;
  logic [DataWidth-1:0] DRData;
  logic                 MemRead;
  logic                 MemWrite;
  logic [AddrWidth-1:0] MemAddress;
  logic [DataWidth-1:0] MemWriteData;
  logic [DataWidth-1:0] MemReadData;

  modport master (
    output IReq, IAddr, DReq, DWrite, DAddr, DWData, MemReadData,
    input  IGnt, IValid, IRData, DGnt, DValid, DRData,
           MemRead, MemWrite, MemAddress, MemWriteData
  );

  modport slave (
    input  IReq, IAddr, DReq, DWrite, DAddr, DWData, MemReadData,
    output IGnt, IValid, IRData, DGnt, DValid, DRData,
           MemRead, MemWrite, MemAddress, MemWriteData
  );
endinterface

// File: rtl/mem_arb_priority.sv
// Grant selection: data wins unless fetch has waited through MaxDataStreak data grants.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int MaxDataStreak = DEF_MAX_DATA_STREAK
) (
  input  logic Clk,
  input  logic Rst,
  input  logic IReq,
  input  logic DReq,
  input  logic idle,
  output logic IGnt,
  output logic DGnt
);
  localparam int SW = cnt_width(MaxDataStreak);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MaxDataStreak);

  logic [SW-1:0] streak;
  logic          starve;

  assign starve = IReq && (streak == STREAK_MAX);
  assign DGnt   = idle && DReq && !starve;
  assign IGnt   = idle && IReq && !DGnt;

  // Streak only counts data grants that actually made a fetch wait.
  always_ff @(posedge Clk) begin
    if (!Rst)                                        streak <= '0;
    else if (IGnt || (idle && !IReq))                streak <= '0;
    else if (DGnt && IReq && streak != STREAK_MAX)   streak <= streak + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store traffic onto one single-ported memory with fixed latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AddrWidth     = DEF_ADDR_W,
  parameter int DataWidth     = DEF_DATA_W,
  parameter int MemLatency    = DEF_MEM_LATENCY,
  parameter int MaxDataStreak = DEF_MAX_DATA_STREAK
) (
  input logic               Clk,
  input logic               Rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CntW = cnt_width(MemLatency - 1);

  arb_state_t           state, state_nx;
  logic [CntW-1:0]      cnt, cnt_nx;
  arb_owner_t           own;
  logic                 lat_write;
  logic [AddrWidth-1:0] lat_addr;
  logic [DataWidth-1:0] lat_wdata;
  logic                 idle, igrant, dgrant, done;

  // Grants are suppressed while reset is asserted so nothing is accepted mid-reset.
  assign idle = (state == ARB_IDLE) && Rst;
  assign done = (state == ARB_ACCESS) && (cnt == '0);

  mem_arb_priority #(.MaxDataStreak(MaxDataStreak)) u_prio (
    .Clk  (Clk),
    .Rst  (Rst),
    .IReq (bus.IReq),
    .DReq (bus.DReq),
    .idle (idle),
    .IGnt (igrant),
    .DGnt (dgrant)
  );

  assign bus.IGnt         = igrant;
  assign bus.DGnt         = dgrant;
  assign bus.MemRead      = (state == ARB_ACCESS) && !lat_write;
  assign bus.MemWrite     = (state == ARB_ACCESS) && lat_write;
  assign bus.MemAddress   = lat_addr;
  assign bus.MemWriteData = lat_wdata;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ARB_IDLE: begin
        if (igrant || dgrant) begin
          state_nx = ARB_ACCESS;
          cnt_nx   = (dgrant && bus.DWrite) ? '0 : CntW'(MemLatency - 1);
        end
      end
      ARB_ACCESS: begin
        if (cnt == '0) state_nx = ARB_IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      own        <= OWN_I;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      bus.IValid <= 1'b0;
      bus.DValid <= 1'b0;
      bus.IRData <= '0;
      bus.DRData <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bus.IValid <= done && (own == OWN_I);
      bus.DValid <= done && (own == OWN_D);
      if (igrant || dgrant) begin
        own       <= dgrant ? OWN_D : OWN_I;
        lat_addr  <= dgrant ? bus.DAddr : bus.IAddr;
        lat_write <= dgrant && bus.DWrite;
      end
      // Write data only tracks data grants so MemWriteData stays put across fetches.
      if (dgrant) lat_wdata <= bus.DWData;
      if (done && !lat_write) begin
        if (own == OWN_I) bus.IRData <= bus.MemReadData;
        else              bus.DRData <= bus.MemReadData;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench; a transaction-level model predicts every output each cycle.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus();

  mem_port_arbiter #(
    .AddrWidth(32), .DataWidth(32), .MemLatency(LAT), .MaxDataStreak(MAXS)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {8'hC3, 8'h5A, a, ~a};
  endfunction

  // Memory attached to the DUT: not affected by the arbiter reset.
  bit [31:0]  mem_arr [256];
  bit [255:0] mem_wr;
  always @(posedge Clk) begin
    if (bus.MemWrite === 1'b1) begin
      mem_arr[bus.MemAddress[7:0]] <= bus.MemWriteData;
      mem_wr[bus.MemAddress[7:0]]  <= 1'b1;
    end
  end
  assign bus.MemReadData = mem_wr[bus.MemAddress[7:0]] ? mem_arr[bus.MemAddress[7:0]]
                                                       : init_word(bus.MemAddress[7:0]);

  // Reference model state
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  int          m_busy, m_streak;
  logic        m_own_d, m_write, m_iv, m_dv;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic [31:0] ref_mem [256];
  bit   [255:0] ref_wr;
  string       gnt_log;
  int          ig_count = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : init_word(a[7:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_streak = 0; m_own_d = 0; m_write = 0; m_iv = 0; m_dv = 0;
    m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
  endtask

  // One clock cycle: check at negedge, advance the model at posedge, return at posedge+1.
  task automatic step();
    logic idle, eg_i, eg_d, ireq, dreq;
    @(negedge Clk);
    ireq = (bus.IReq === 1'b1);
    dreq = (bus.DReq === 1'b1);
    idle = (m_busy == 0) && (Rst === 1'b1);
    eg_d = idle && dreq && !(ireq && m_streak == MAXS);
    eg_i = idle && ireq && !eg_d;
    if (bus.IGnt === 1'b1) begin gnt_log = {gnt_log, "I"}; ig_count++; end
    if (bus.DGnt === 1'b1) gnt_log = {gnt_log, "D"};
    if (chk_en) begin
      chk("IGnt",         32'(bus.IGnt),     32'(eg_i));
      chk("DGnt",         32'(bus.DGnt),     32'(eg_d));
      chk("MemRead",      32'(bus.MemRead),  32'(m_busy > 0 && !m_write));
      chk("MemWrite",     32'(bus.MemWrite), 32'(m_busy > 0 && m_write));
      chk("MemAddress",   bus.MemAddress,    m_addr);
      chk("MemWriteData", bus.MemWriteData,  m_wdata);
      chk("IValid",       32'(bus.IValid),   32'(m_iv));
      chk("DValid",       32'(bus.DValid),   32'(m_dv));
      chk("IRData",       bus.IRData,        m_ird);
      chk("DRData",       bus.DRData,        m_drd);
    end
    @(posedge Clk);
    if (Rst !== 1'b1) begin
      // A store in flight still hits the memory on this edge.
      if (m_busy > 0 && m_write) begin
        ref_mem[m_addr[7:0]] = m_wdata; ref_wr[m_addr[7:0]] = 1'b1;
      end
      model_reset();
    end else begin
      m_iv = 0; m_dv = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          if (m_write) begin
            ref_mem[m_addr[7:0]] = m_wdata; ref_wr[m_addr[7:0]] = 1'b1;
          end else if (m_own_d) m_drd = ref_read(m_addr);
          else                  m_ird = ref_read(m_addr);
          if (m_own_d) m_dv = 1; else m_iv = 1;
        end
      end else begin
        if (eg_i || eg_d) begin
          m_own_d = eg_d;
          m_addr  = eg_d ? bus.DAddr : bus.IAddr;
          m_write = eg_d && (bus.DWrite === 1'b1);
          if (eg_d) m_wdata = bus.DWData;
          m_busy  = m_write ? 1 : LAT;
        end
        if (eg_i || !ireq)              m_streak = 0;
        else if (eg_d && m_streak < MAXS) m_streak++;
      end
    end
    #1;
  endtask

  initial begin
    int base;
    bus.IReq = 1; bus.DReq = 1; bus.DWrite = 0;
    bus.IAddr = 32'h10; bus.DAddr = 32'h20; bus.DWData = 32'h0;
    model_reset();
    #1;
    // Reset held with both requests high
    step();
    chk_en = 1'b1;
    step();
    step();
    chk("reset_IRData", bus.IRData, 32'h0);

    Rst = 1; bus.IReq = 0; bus.DReq = 0;
    step();

    // Single fetch
    bus.IReq = 1; bus.IAddr = 32'h10;
    step();
    bus.IReq = 0;
    chk("fetch_c1_MemRead", 32'(bus.MemRead), 32'd1);
    chk("fetch_c1_addr", bus.MemAddress, 32'h10);
    step();
    chk("fetch_c2_MemRead", 32'(bus.MemRead), 32'd1);
    step();
    chk("fetch_c3_IValid", 32'(bus.IValid), 32'd1);
    chk("fetch_c3_IRData", bus.IRData, 32'hDEADBEEF);

    // Store then load
    bus.DReq = 1; bus.DWrite = 1; bus.DAddr = 32'h40; bus.DWData = 32'h12345678;
    step();
    bus.DReq = 0;
    chk("store_c1_MemWrite", 32'(bus.MemWrite), 32'd1);
    step();
    chk("store_c2_MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("store_c2_DValid", 32'(bus.DValid), 32'd1);
    chk("store_DRData_kept", bus.DRData, 32'h0);
    bus.DReq = 1; bus.DWrite = 0; bus.DAddr = 32'h40;
    step();
    bus.DReq = 0;
    step();
    step();
    chk("load_DValid", 32'(bus.DValid), 32'd1);
    chk("load_DRData", bus.DRData, 32'h12345678);

    // Contention
    gnt_log = "";
    bus.IReq = 1; bus.DReq = 1; bus.DWrite = 0; bus.IAddr = 32'h08; bus.DAddr = 32'h44;
    for (int i = 0; i < 40 && gnt_log.len() < 10; i++) step();
    checks++;
    assert (gnt_log == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order: got %s expected DDDDIDDDDI", gnt_log);
    end
    bus.IReq = 0; bus.DReq = 0;
    for (int i = 0; i < 4; i++) step();

    // Reset during the second access cycle of a fetch
    bus.IReq = 1; bus.IAddr = 32'h24;
    step();
    bus.IReq = 0;
    step();
    Rst = 0;
    step();
    Rst = 1;
    chk("midrst_MemRead", 32'(bus.MemRead), 32'd0);
    chk("midrst_IValid", 32'(bus.IValid), 32'd0);
    step();
    bus.IReq = 1; bus.IAddr = 32'h10;
    step();
    bus.IReq = 0;
    step();
    step();
    chk("postrst_IValid", 32'(bus.IValid), 32'd1);
    chk("postrst_IRData", bus.IRData, 32'hDEADBEEF);
    step();

    // Fetch request pulsed only while a load is in progress
    base = ig_count;
    bus.DReq = 1; bus.DWrite = 0; bus.DAddr = 32'h40;
    step();
    bus.DReq = 0; bus.IReq = 1;
    step();
    bus.IReq = 0;
    for (int i = 0; i < 4; i++) step();
    chk("early_drop_igrants", 32'(ig_count - base), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      bus.IReq   = ($urandom_range(0, 3) != 0);
      bus.DReq   = ($urandom_range(0, 2) != 0);
      bus.DWrite = $urandom_range(0, 1);
      bus.IAddr  = 32'($urandom_range(0, 255));
      bus.DAddr  = 32'($urandom_range(0, 255));
      bus.DWData = $urandom;
      Rst        = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
